int_to_fp: RTL and testbench

Multi-cycle 32-bit integer to IEEE-754 single-precision converter. It sits directly upstream of the floating-point adder and produces the A/B operands from integer sources. It uses the same start/busy/ready handshake as the adder, so its Y and ready can drive an adder operand and start with no glue logic. Conversion normalises one bit per clock and rounds to nearest-even.

---
 rtl/int_to_fp.sv | 129 ++++++++++++
 tb/tb_int_to_fp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter.
// Normalises one bit per clock, rounds to nearest-even; start/busy/ready handshake.
module int_to_fp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] I,
  output logic        ready,
  output logic        busy,
  output logic [31:0] Y
);

  typedef enum logic [2:0] {StIdle, StLoad, StNorm, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] int_q, int_d;
  logic [31:0] mag_q, mag_d;
  logic [31:0] y_q, y_d;
  logic [7:0]  exp_q, exp_d;
  logic        signed_q, signed_d;
  logic        sign_q, sign_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        load_sign;
  logic [31:0] load_mag;
  logic        round_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_rnd;

  // Two's complement of 0x80000000 stays 0x80000000, which is the right magnitude.
  assign load_sign = signed_q & int_q[31];
  assign load_mag  = load_sign ? (~int_q + 32'd1) : int_q;

  assign round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign frac_sum = {1'b0, mag_q[30:8]} + {23'd0, round_up};
  // On carry-out the fraction wraps to zero and the exponent absorbs it.
  assign exp_rnd  = exp_q + {7'd0, frac_sum[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = (load_mag == 32'd0) ? StDone : StNorm;
      StNorm:  if (mag_q[31]) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    int_d    = int_q;
    signed_d = signed_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    y_d      = y_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        ready_d = 1'b0;
        if (start) begin
          int_d    = I;
          signed_d = is_signed;
          busy_d   = 1'b1;
        end
      end
      StLoad: begin
        sign_d = load_sign;
        mag_d  = load_mag;
        if (load_mag == 32'd0) begin
          y_d = 32'd0;
        end else begin
          exp_d = 8'd158;
        end
      end
      StNorm: begin
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StRound: y_d = {sign_q, exp_rnd, frac_sum[22:0]};
      StDone: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q    <= 32'd0;
      signed_q <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      y_q      <= 32'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      int_q    <= int_d;
      signed_q <= signed_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      y_q      <= y_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign Y     = y_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Scoreboard bench for int_to_fp: driver pushes expected (Y, ready edge), monitor pops on ready.
module tb_int_to_fp;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] I;
  logic        ready;
  logic        busy;
  logic [31:0] Y;

  int_to_fp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .I         (I),
    .ready     (ready),
    .busy      (busy),
    .Y         (Y)
  );

  typedef struct {
    logic [31:0] y;
    int unsigned accept;
    int unsigned done;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Plain integer-to-float rounding; lat = cycles from accept edge to ready edge.
  function automatic logic [31:0] ref_fp(input logic [31:0] i, input logic s, output int lat);
    logic        sg;
    logic [63:0] m;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    int          p;
    int          sh;
    sg = s & i[31];
    m  = sg ? (64'h1_0000_0000 - {32'd0, i}) : {32'd0, i};
    if (m == 64'd0) begin
      lat = 2;
      return 32'd0;
    end
    p = 31;
    while (m[p] == 1'b0) p--;
    lat = 4 + (31 - p);
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {sg, 8'(p + 127), q[22:0]};
  endfunction

  // Monitor: overlap, busy coverage of each conversion, and result/latency on ready.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ready && busy) begin
        errors++;
        $display("FAIL overlap: ready=%0b busy=%0b, required not both high at cycle %0d",
                 ready, busy, cyc);
      end
      if (sb.size() > 0 && cyc >= sb[0].accept && cyc < sb[0].done) begin
        checks++;
        if (!busy) begin
          errors++;
          $display("FAIL busy_hold: busy=0, required 1 at cycle %0d", cyc);
        end
      end
      if (ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: ready=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (Y !== e.y || cyc != e.done) begin
            errors++;
            $display("FAIL result: Y=%08h at cycle %0d, required Y=%08h at cycle %0d",
                     Y, cyc, e.y, e.done);
          end
        end
      end
    end
  end

  // Wait for idle while wiggling start/I; a busy DUT must ignore all of it.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy) begin
      if (n >= 100) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
        break;
      end
      start     = 1'($urandom_range(0, 1));
      I         = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] i, input logic s, input logic [31:0] y,
                       input int lat, input int gap);
    wait_idle();
    repeat (gap) @(negedge clk);
    start     = 1'b1;
    I         = i;
    is_signed = s;
    sb.push_back('{y: y, accept: cyc + 1, done: cyc + 1 + lat});
    @(negedge clk);
    start     = 1'b0;
    I         = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_ref(input logic [31:0] i, input logic s, input int gap);
    logic [31:0] y;
    int          lat;
    y = ref_fp(i, s, lat);
    issue(i, s, y, lat, gap);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    I         = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_y", Y, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived results and latencies.
    issue(32'h0000_0001, 1'b0, 32'h3F80_0000, 35, 0);
    issue(32'h0000_0000, 1'b0, 32'h0000_0000, 2, 1);
    issue(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 35, 0);
    issue(32'h8000_0000, 1'b1, 32'hCF00_0000, 4, 2);
    issue(32'h8000_0000, 1'b0, 32'h4F00_0000, 4, 0);
    issue(32'h0100_0001, 1'b0, 32'h4B80_0000, 11, 0);
    issue(32'h0100_0003, 1'b0, 32'h4B80_0002, 11, 1);
    issue(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 4, 0);
    issue(32'h0000_0007, 1'b0, 32'h40E0_0000, 33, 0);

    // Random: mostly uniform, a quarter shifted down to exercise long normalisation.
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 31);
      issue_ref(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    // Abandon a conversion of 1 mid-normalisation; previous Y is nonzero.
    issue(32'h0000_0001, 1'b0, 32'h3F80_0000, 35, 0);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midreset_ready", {31'd0, ready}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_y", Y, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_reset_no_ready", {31'd0, ready}, 32'd0);
    end

    issue(32'h0100_0003, 1'b0, 32'h4B80_0002, 11, 0);
    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
